// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: sensor FSM states, frame size, default timings
// and the additive checksum also used by the host controller.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        RESP_DLY,
        ACK_L,
        ACK_H,
        BIT_L,
        BIT_H,
        END_L
    } state_t;

    localparam int FRAME_BITS = 40;

    localparam int DEF_CYC_PER_US   = 100;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_RESP_DLY_US  = 30;
    localparam int DEF_ACK_US       = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_US      = 27;
    localparam int DEF_BIT1_US      = 70;

    // Cycles at the start of a released phase during which our own previous
    // low is still draining out of the synchronizer.
    localparam int SETTLE_CYC = 4;

    function automatic logic [7:0] crc8_sum(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
        return b0 + b1 + b2 + b3;
    endfunction

endpackage

// File: rtl/dht11_bit_sync.sv
// Two-flop synchronizer for the single-wire bus; resets to the idle-high level.
module dht11_bit_sync (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor-side emulator: detects a host start pulse, then answers with
// the ack sequence and a 40-bit frame on an open-drain single-wire bus.
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int unsigned CYC_PER_US   = DEF_CYC_PER_US,
    parameter int unsigned START_MIN_US = DEF_START_MIN_US,
    parameter int unsigned RESP_DLY_US  = DEF_RESP_DLY_US,
    parameter int unsigned ACK_US       = DEF_ACK_US,
    parameter int unsigned BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int unsigned BIT0_US      = DEF_BIT0_US,
    parameter int unsigned BIT1_US      = DEF_BIT1_US
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    inout  wire        DHT_DATA,
    input  logic [7:0] HUM_INT,
    input  logic [7:0] HUM_FLOAT,
    input  logic [7:0] TEMP_INT,
    input  logic [7:0] TEMP_FLOAT,
    input  logic [7:0] CRC_XOR,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       DRIVE_LOW
);

    localparam logic [23:0] START_CYC = 24'(START_MIN_US * CYC_PER_US);
    localparam logic [23:0] RESP_LAST = 24'(RESP_DLY_US * CYC_PER_US - 1);
    localparam logic [23:0] ACK_LAST  = 24'(ACK_US * CYC_PER_US - 1);
    localparam logic [23:0] BITL_LAST = 24'(BIT_LOW_US * CYC_PER_US - 1);
    localparam logic [23:0] BIT0_LAST = 24'(BIT0_US * CYC_PER_US - 1);
    localparam logic [23:0] BIT1_LAST = 24'(BIT1_US * CYC_PER_US - 1);
    localparam logic [23:0] SETTLE    = 24'(SETTLE_CYC);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [39:0] frame_q, frame_d;
    logic        armed_q, armed_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        din_s;
    logic        dur_last;
    logic        contend;

    dht11_bit_sync u_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (DHT_DATA),
        .q_o (din_s)
    );

    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Every timed phase lasts exactly (last + 1) cycles; the counter restarts at 0 on entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 24'd1;
        idx_d    = idx_q;
        frame_d  = frame_q;
        armed_d  = armed_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        dur_last = 1'b0;
        contend  = (state_q inside {RESP_DLY, ACK_H, BIT_H}) && (cnt_q >= SETTLE) && !din_s;

        case (state_q)
            RESP_DLY: dur_last = (cnt_q == RESP_LAST);
            ACK_L,
            ACK_H:    dur_last = (cnt_q == ACK_LAST);
            BIT_L,
            END_L:    dur_last = (cnt_q == BITL_LAST);
            BIT_H:    dur_last = (cnt_q == (frame_q[idx_q] ? BIT1_LAST : BIT0_LAST));
            default:  dur_last = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (din_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = HOST_LOW;
                    cnt_d   = 24'd1;
                end
            end
            HOST_LOW: begin
                if (!din_s) begin
                    if (cnt_q == '1) cnt_d = cnt_q;
                end else if (cnt_q >= START_CYC) begin
                    frame_d = {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT,
                               crc8_sum(HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT) ^ CRC_XOR};
                    idx_d   = 6'(FRAME_BITS - 1);
                    state_d = RESP_DLY;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (contend) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    armed_d = 1'b0;
                end else if (dur_last) begin
                    cnt_d = '0;
                    case (state_q)
                        RESP_DLY: state_d = ACK_L;
                        ACK_L:    state_d = ACK_H;
                        ACK_H:    state_d = BIT_L;
                        BIT_L:    state_d = BIT_H;
                        BIT_H: begin
                            if (idx_q == 6'd0) begin
                                state_d = END_L;
                            end else begin
                                idx_d   = idx_q - 6'd1;
                                state_d = BIT_L;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            armed_d = 1'b0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        DRIVE_LOW = state_q inside {ACK_L, BIT_L, END_L};
        BUSY      = state_q inside {RESP_DLY, ACK_L, ACK_H, BIT_L, BIT_H, END_L};
        DONE      = done_q;
        ERR       = err_q;
    end

    assign DHT_DATA = DRIVE_LOW ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Directed bench for dht11_sensor_emu at 1 cycle/us with a 1800 us start
// threshold, decoding the bus waveform and checking it against hand-computed frames.
module tb_dht11_sensor_emu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       hostPull = 1'b0;
    logic [7:0] humInt = 8'h00;
    logic [7:0] humFloat = 8'h00;
    logic [7:0] tempInt = 8'h00;
    logic [7:0] tempFloat = 8'h00;
    logic [7:0] crcXor = 8'h00;
    wire        dhtBus;
    logic       busy, done, err, driveLow;

    int errors = 0;
    int checks = 0;
    int doneTotal = 0;
    int errTotal = 0;

    assign dhtBus = hostPull ? 1'b0 : 1'bz;
    pullup (dhtBus);

    always #5 clk = ~clk;

    dht11_sensor_emu #(
        .CYC_PER_US   (1),
        .START_MIN_US (1800)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .EN         (en),
        .DHT_DATA   (dhtBus),
        .HUM_INT    (humInt),
        .HUM_FLOAT  (humFloat),
        .TEMP_INT   (tempInt),
        .TEMP_FLOAT (tempFloat),
        .CRC_XOR    (crcXor),
        .BUSY       (busy),
        .DONE       (done),
        .ERR        (err),
        .DRIVE_LOW  (driveLow)
    );

    always @(negedge clk) begin
        if (done) doneTotal <= doneTotal + 1;
        if (err) errTotal <= errTotal + 1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic setInputs(input logic [7:0] h, input logic [7:0] hf,
                             input logic [7:0] t, input logic [7:0] tf, input logic [7:0] x);
        humInt = h; humFloat = hf; tempInt = t; tempFloat = tf; crcXor = x;
    endtask

    task automatic hostStart(input int len);
        @(posedge clk); #1 hostPull = 1'b1;
        repeat (len) @(posedge clk);
        #1 hostPull = 1'b0;
    endtask

    task automatic waitLevel(input logic lvl, input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (dhtBus === lvl) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Counts the run of 'lvl' that includes the current negedge sample.
    task automatic measureRun(input logic lvl, input int limit, output int len, output bit to);
        len = 1;
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (dhtBus !== lvl) begin
                to = 1'b0;
                break;
            end
            len++;
        end
    endtask

    task automatic captureFrame(input int modBit, output logic [39:0] bits,
                                output int ackLow, output int ackHigh, output int endLow,
                                output int badTiming, output int hi1Len, output int hi0Len,
                                output bit to);
        bit t;
        int lowLen, hiLen;
        bits = '0; ackLow = 0; ackHigh = 0; endLow = 0;
        badTiming = 0; hi1Len = 0; hi0Len = 0;
        waitLevel(1'b0, 400, to);
        if (!to) measureRun(1'b0, 200, ackLow, to);
        if (!to) measureRun(1'b1, 200, ackHigh, to);
        for (int i = 39; i >= 0; i--) begin
            if (to) break;
            if (i == modBit) humInt = 8'h40;
            measureRun(1'b0, 200, lowLen, t);
            to |= t;
            if (!to) measureRun(1'b1, 200, hiLen, t);
            to |= t;
            bits[i] = (hiLen > 48);
            if (bits[i]) hi1Len = hiLen;
            else hi0Len = hiLen;
            if (lowLen != 50 || (hiLen != 27 && hiLen != 70)) badTiming++;
        end
        if (!to) measureRun(1'b0, 200, endLow, to);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({driveLow, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got drv/busy/done/err=%b required 0000",
                     {driveLow, busy, done, err});
        end
        checks++;
        if (dhtBus !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_bus: got %b required 1", dhtBus);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal;
        logic [39:0] bits;
        int ackLow, ackHigh, endLow, bad, h1, h0, d0, e0;
        bit to;
        setInputs(8'h37, 8'h00, 8'h19, 8'h05, 8'h00);
        d0 = doneTotal; e0 = errTotal;
        hostStart(1800);
        captureFrame(-1, bits, ackLow, ackHigh, endLow, bad, h1, h0, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL nominal_timeout: got %b required 0", to); end
        checks++;
        if (ackLow != 80) begin errors++; $display("[TB] FAIL nominal_ack_low: got %0d required 80", ackLow); end
        checks++;
        if (ackHigh != 80) begin errors++; $display("[TB] FAIL nominal_ack_high: got %0d required 80", ackHigh); end
        checks++;
        if (bits !== 40'h3700190555) begin errors++; $display("[TB] FAIL nominal_frame: got %h required 3700190555", bits); end
        checks++;
        if (endLow != 50) begin errors++; $display("[TB] FAIL nominal_end_low: got %0d required 50", endLow); end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL nominal_bit_timing: got %0d bad bits required 0", bad); end
        checks++;
        if (doneTotal - d0 != 1) begin errors++; $display("[TB] FAIL nominal_done: got %0d pulses required 1", doneTotal - d0); end
        checks++;
        if (errTotal - e0 != 0) begin errors++; $display("[TB] FAIL nominal_err: got %0d pulses required 0", errTotal - e0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nominal_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_short_start;
        logic [39:0] bits;
        int ackLow, ackHigh, endLow, bad, h1, h0, d0, e0;
        bit to, sawDrive, sawBusy;
        setInputs(8'h37, 8'h00, 8'h19, 8'h05, 8'h00);
        d0 = doneTotal; e0 = errTotal;
        sawDrive = 1'b0; sawBusy = 1'b0;
        // One cycle short of the acceptance threshold.
        hostStart(1799);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (driveLow) sawDrive = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checks++;
        if (sawDrive) begin errors++; $display("[TB] FAIL short_drive: got drive required none"); end
        checks++;
        if (sawBusy) begin errors++; $display("[TB] FAIL short_busy: got busy=1 required 0"); end
        checks++;
        if ((doneTotal - d0) + (errTotal - e0) != 0) begin
            errors++;
            $display("[TB] FAIL short_pulses: got done=%0d err=%0d required 0/0", doneTotal - d0, errTotal - e0);
        end
        hostStart(1800);
        captureFrame(-1, bits, ackLow, ackHigh, endLow, bad, h1, h0, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL short_retry_timeout: got %b required 0", to); end
        checks++;
        if (bits !== 40'h3700190555) begin errors++; $display("[TB] FAIL short_retry_frame: got %h required 3700190555", bits); end
        checks++;
        if (doneTotal - d0 != 1) begin errors++; $display("[TB] FAIL short_retry_done: got %0d required 1", doneTotal - d0); end
    endtask

    task automatic test_crc_injection;
        logic [39:0] bits;
        int ackLow, ackHigh, endLow, bad, h1, h0;
        bit to;
        setInputs(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01);
        hostStart(1800);
        captureFrame(-1, bits, ackLow, ackHigh, endLow, bad, h1, h0, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL crc_timeout: got %b required 0", to); end
        checks++;
        if (bits !== 40'hFFFFFFFFFD) begin errors++; $display("[TB] FAIL crc_frame: got %h required fffffffffd", bits); end
        checks++;
        if (h1 != 70) begin errors++; $display("[TB] FAIL crc_bit1_high: got %0d required 70", h1); end
        checks++;
        if (h0 != 27) begin errors++; $display("[TB] FAIL crc_bit0_high: got %0d required 27", h0); end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL crc_bit_timing: got %0d bad bits required 0", bad); end
        crcXor = 8'h00;
    endtask

    task automatic test_contention;
        int len, d0, e0, errCycles;
        bit to, t, drvAtErr;
        setInputs(8'h37, 8'h00, 8'h19, 8'h05, 8'h00);
        d0 = doneTotal; e0 = errTotal;
        errCycles = 0; drvAtErr = 1'b0;
        hostStart(1800);
        waitLevel(1'b0, 400, to);
        if (!to) measureRun(1'b0, 200, len, to);
        if (!to) measureRun(1'b1, 200, len, to);
        for (int i = 39; i > 12; i--) begin
            if (to) break;
            measureRun(1'b0, 200, len, t);
            to |= t;
            if (!to) measureRun(1'b1, 200, len, t);
            to |= t;
        end
        // Bit 12's low, after which we sit in its high phase.
        if (!to) measureRun(1'b0, 200, len, to);
        repeat (10) @(negedge clk);
        hostPull = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err) begin
                errCycles++;
                if (driveLow) drvAtErr = 1'b1;
            end
        end
        hostPull = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL contention_timeout: got %b required 0", to); end
        checks++;
        if (errTotal - e0 != 1) begin errors++; $display("[TB] FAIL contention_err: got %0d pulses required 1", errTotal - e0); end
        checks++;
        if (errCycles != 1) begin errors++; $display("[TB] FAIL contention_err_window: got %0d required 1", errCycles); end
        checks++;
        if (drvAtErr) begin errors++; $display("[TB] FAIL contention_release: got drive=1 at err required 0"); end
        checks++;
        if (doneTotal - d0 != 0) begin errors++; $display("[TB] FAIL contention_done: got %0d required 0", doneTotal - d0); end
        checks++;
        if (busy !== 1'b0 || dhtBus !== 1'b1) begin
            errors++;
            $display("[TB] FAIL contention_idle: got busy=%b bus=%b required 0/1", busy, dhtBus);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [39:0] bits;
        int ackLow, ackHigh, endLow, bad, h1, h0, d0, e0;
        bit to;
        setInputs(8'h37, 8'h00, 8'h19, 8'h05, 8'h00);
        d0 = doneTotal; e0 = errTotal;
        hostStart(1800);
        waitLevel(1'b0, 400, to);
        repeat (20) @(negedge clk);
        checks++;
        if (to !== 1'b0 || busy !== 1'b1 || driveLow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_in_ack: got to=%b busy=%b drv=%b required 0/1/1", to, busy, driveLow);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({driveLow, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got drv/busy/done/err=%b required 0000", {driveLow, busy, done, err});
        end
        checks++;
        if (dhtBus !== 1'b1) begin errors++; $display("[TB] FAIL midreset_bus: got %b required 1", dhtBus); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ((doneTotal - d0) + (errTotal - e0) != 0) begin
            errors++;
            $display("[TB] FAIL midreset_pulses: got done=%0d err=%0d required 0/0", doneTotal - d0, errTotal - e0);
        end
        hostStart(1800);
        captureFrame(-1, bits, ackLow, ackHigh, endLow, bad, h1, h0, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL midreset_retry_timeout: got %b required 0", to); end
        checks++;
        if (bits !== 40'h3700190555) begin errors++; $display("[TB] FAIL midreset_retry_frame: got %h required 3700190555", bits); end
        checks++;
        if (doneTotal - d0 != 1) begin errors++; $display("[TB] FAIL midreset_retry_done: got %0d required 1", doneTotal - d0); end
    endtask

    task automatic test_input_stability;
        logic [39:0] bits;
        int ackLow, ackHigh, endLow, bad, h1, h0;
        bit to;
        setInputs(8'h37, 8'h00, 8'h19, 8'h05, 8'h00);
        hostStart(1800);
        captureFrame(5, bits, ackLow, ackHigh, endLow, bad, h1, h0, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("[TB] FAIL stability_timeout: got %b required 0", to); end
        checks++;
        if (bits !== 40'h3700190555) begin errors++; $display("[TB] FAIL stability_frame: got %h required 3700190555", bits); end
        checks++;
        if (humInt !== 8'h40) begin errors++; $display("[TB] FAIL stability_input_changed: got %h required 40", humInt); end
        humInt = 8'h37;
    endtask

    initial begin
        $display("[TB] dht11_sensor_emu directed test start");
        test_reset();
        test_nominal();
        test_short_start();
        test_crc_injection();
        test_contention();
        test_reset_mid_frame();
        test_input_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dht11_sensor_emu.md
Name: dht11_sensor_emu

Overview:
- Emulates the sensor end of the DHT11 single-wire protocol. Open-drain: the block either drives the bus low or releases it.
- Waits for a host start pulse, then answers with the ack sequence and a 40-bit frame built from register inputs. CRC is generated internally.
- Used on-board as a loopback target for the DHT11 host controller and as a bench model of the sensor.

Parameters:
- CYC_PER_US, 100, clock cycles per microsecond (100 MHz default).
- START_MIN_US, 18000, minimum host low time accepted as a start pulse.
- RESP_DLY_US, 30, released gap after the host lets go, before the ack.
- ACK_US, 80, duration of ack low and of ack high.
- BIT_LOW_US, 50, low preamble of every bit and of the end marker.
- BIT0_US, 27, high time for a 0 bit.
- BIT1_US, 70, high time for a 1 bit.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- EN  in  1  enable; 0 forces release and IDLE
- DHT_DATA  inout  1  bus; driven 0 when DRIVE_LOW=1, else high-Z
- HUM_INT  in  8  humidity integer byte
- HUM_FLOAT  in  8  humidity fraction byte
- TEMP_INT  in  8  temperature integer byte
- TEMP_FLOAT  in  8  temperature fraction byte
- CRC_XOR  in  8  XOR mask applied to the generated CRC (fault injection; 0 in normal use)
- BUSY  out  1  high from start-pulse acceptance until frame end or abort
- DONE  out  1  one-cycle pulse when a frame completes
- ERR  out  1  one-cycle pulse on a contention abort
- DRIVE_LOW  out  1  current pull-down enable (debug)

Behaviour:
- Reset/EN=0 values: DRIVE_LOW=0, BUSY=0, DONE=0, ERR=0, state IDLE, counters 0. RST takes effect at the next edge, also mid-frame, so the bus is released within 1 cycle.
- Bus input passes through a 2-FF synchronizer (din_s), so observation latency is 2 cycles. All durations are exactly N_US*CYC_PER_US cycles, counted with a 24-bit counter.
- IDLE: DRIVE_LOW=0. din_s=0 -> HOST_LOW, counter cleared.
- HOST_LOW:
  - Counts while din_s=0.
  - din_s=1 with count < START_MIN_US*CYC -> IDLE (glitch or short pulse; no ERR).
  - din_s=1 with count >= threshold -> latch the frame, BUSY=1, go to RESP_DLY.
  - A low held indefinitely waits indefinitely.
- Frame latch: frame = {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC}.
  - CRC = (HUM_INT+HUM_FLOAT+TEMP_INT+TEMP_FLOAT) mod 256, XOR CRC_XOR.
  - Input changes after the latch do not affect the frame in flight.
- RESP_DLY: released for RESP_DLY_US.
- ACK_L: driven low for ACK_US.
- ACK_H: released for ACK_US.
- BIT_L: driven low for BIT_LOW_US. Bits are sent MSB first, frame[39] first, with bit index 39 down to 0.
- BIT_H: released for BIT1_US if the current bit is 1, else BIT0_US. Then the index decrements and the FSM returns to BIT_L; after bit 0 it goes to END_L.
- END_L: driven low for BIT_LOW_US, then release. DONE pulses in the first cycle of IDLE and BUSY falls in that same cycle.
- Contention check in the released phases (RESP_DLY, ACK_H, BIT_H):
  - Ignore the first 4 cycles of the phase (synchronizer settle).
  - din_s=0 after that -> release, ERR pulse, IDLE, BUSY=0, no DONE.
- EN falling mid-frame: same as reset, with no ERR and no DONE.
- After DONE or ERR, IDLE requires din_s=1 for at least 1 cycle before a new start is recognised. This stops the block retriggering on its own END_L low.
- The block never drives the bus high.

Decomposition:
- Package dht11_pkg holds:
  - the state enum (IDLE, HOST_LOW, RESP_DLY, ACK_L, ACK_H, BIT_L, BIT_H, END_L)
  - FRAME_BITS=40
  - default microsecond constants
  - a crc8_sum function shared with the host block
- One sub-module: dht11_bit_sync (2-FF synchronizer, reset to 1).
- The FSM, counter and shift index stay in dht11_sensor_emu.

Test Plan:
- Nominal frame: CYC_PER_US=10, inputs 0x37/0x00/0x19/0x05, CRC_XOR=0; host low 18 ms then release. Required response:
  - ack low 800 cycles, then high 800 cycles
  - 40 bits decode to 0x37 00 19 05 55
  - DONE pulses once, BUSY=0 afterwards
- Short start: host low 17.9 ms -> no bus drive, BUSY stays 0, no DONE/ERR. A subsequent 18 ms pulse still gets a full frame.
- CRC injection: inputs 0xFF/0xFF/0xFF/0xFF, CRC_XOR=0x01.
  - Sent CRC = 0xFC^0x01 = 0xFD.
  - Bit-1 highs measure 700 cycles, bit-0 highs 270 cycles.
- Contention: bench pulls the bus low for 20 us during bit 12's high phase -> ERR one pulse, DRIVE_LOW=0 within 1 cycle after detection, BUSY=0, no DONE.
- Reset mid-frame: assert RST during ACK_L -> DRIVE_LOW=0 at the next edge, all outputs at reset values. A new start pulse then gets a complete correct frame.
- Input stability: change HUM_INT from 0x37 to 0x40 during bit 5 -> the transmitted frame still carries 0x37 and CRC 0x55.
